// File: rtl/raw_gen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | raw_gen_pkg                                                            |
// | Shared pattern codes, sequencer states and startup constant.           |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package raw_gen_pkg;

    typedef enum logic [2:0] {
        PAT_COLORBAR = 3'd0,
        PAT_RED      = 3'd1,
        PAT_GREEN    = 3'd2,
        PAT_BLUE     = 3'd3,
        PAT_CHECKER  = 3'd4,
        PAT_WHITE    = 3'd5
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } seq_state_e;

    localparam int STARTUP_CLKS_DEFAULT = 128;

    // Step to the next pattern code, wrapping after the last legal code.
    function automatic logic [2:0] pat_next(input logic [2:0] sel, input logic [2:0] last_code);
        return (sel >= last_code) ? 3'd0 : sel + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_edge_det.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | frame_edge_det                                                         |
// | Registers frame valid and flags the first clock after it falls.        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module frame_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic fv,
    output logic frame_end
);

    logic r_fv_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fv_q <= 1'b0;
        end else begin
            r_fv_q <= fv;
        end
    end

    assign frame_end = r_fv_q & ~fv;

endmodule
`default_nettype wire

// File: rtl/raw_pattern_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | raw_pattern_sequencer                                                  |
// | Steps a raw pattern generator through its codes on frame boundaries.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module raw_pattern_sequencer
    import raw_gen_pkg::*;
#(
    parameter int NUM_PATTERNS = 6,
    parameter int FCNT_W       = 11,
    parameter int STARTUP_CLKS = STARTUP_CLKS_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fv,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_first,
    input  logic [FCNT_W-1:0] cfg_dwell,
    input  logic              cfg_loop,
    output logic              gen_en,
    output logic [2:0]        pattern_sel,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              done
);

    localparam int                c_su_w      = $clog2(STARTUP_CLKS + 2);
    localparam logic [2:0]        c_last_code = 3'(NUM_PATTERNS - 1);
    localparam logic [FCNT_W-1:0] c_fcnt_max  = '1;

    seq_state_e          r_state,       w_state_nxt;
    logic                r_gen_en,      w_gen_en_nxt;
    logic [2:0]          r_sel,         w_sel_nxt;
    logic [FCNT_W-1:0]   r_fcnt,        w_fcnt_nxt;
    logic [FCNT_W-1:0]   r_dwell_cnt,   w_dwell_cnt_nxt;
    logic                r_done,        w_done_nxt;
    logic [2:0]          r_cfg_first,   w_cfg_first_nxt;
    logic [FCNT_W-1:0]   r_cfg_dwell,   w_cfg_dwell_nxt;
    logic                r_cfg_loop,    w_cfg_loop_nxt;
    logic [c_su_w-1:0]   r_su_cnt;

    logic                w_frame_end;
    logic                w_startup_done;
    logic [2:0]          w_last_sel;
    logic [FCNT_W-1:0]   w_dwell_inc;
    logic                w_dwell_wrap;
    logic                w_pass_end;

    frame_edge_det u_frame_edge_det (
        .clk       (clk),
        .rstn      (rstn),
        .fv        (fv),
        .frame_end (w_frame_end)
    );

    assign w_startup_done = (r_su_cnt == c_su_w'(STARTUP_CLKS));
    assign cfg_ready      = (r_state == ST_IDLE) & w_startup_done;

    // A single pass ends on the pattern just before the first one, modulo the code count.
    assign w_last_sel   = (r_cfg_first == 3'd0) ? c_last_code : r_cfg_first - 3'd1;
    assign w_dwell_inc  = r_dwell_cnt + FCNT_W'(1);
    assign w_dwell_wrap = (w_dwell_inc == r_cfg_dwell);
    assign w_pass_end   = w_frame_end & w_dwell_wrap & ~r_cfg_loop & (r_sel == w_last_sel);

    always_comb begin
        w_state_nxt     = r_state;
        w_gen_en_nxt    = r_gen_en;
        w_sel_nxt       = r_sel;
        w_fcnt_nxt      = r_fcnt;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_done_nxt      = 1'b0;
        w_cfg_first_nxt = r_cfg_first;
        w_cfg_dwell_nxt = r_cfg_dwell;
        w_cfg_loop_nxt  = r_cfg_loop;

        if (cfg_valid && cfg_ready) begin
            w_cfg_first_nxt = ({1'b0, cfg_first} >= 4'(NUM_PATTERNS)) ? 3'd0 : cfg_first;
            w_cfg_dwell_nxt = (cfg_dwell == '0) ? FCNT_W'(1) : cfg_dwell;
            w_cfg_loop_nxt  = cfg_loop;
        end

        case (r_state)
            ST_IDLE: begin
                if (start && !stop && w_startup_done) begin
                    w_state_nxt     = ST_ARMED;
                    w_sel_nxt       = r_cfg_first;
                    w_fcnt_nxt      = '0;
                    w_dwell_cnt_nxt = '0;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_frame_end) begin
                    w_state_nxt  = ST_RUN;
                    w_gen_en_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_frame_end) begin
                    if (r_fcnt != c_fcnt_max) begin
                        w_fcnt_nxt = r_fcnt + FCNT_W'(1);
                    end
                    if (w_dwell_wrap) begin
                        w_dwell_cnt_nxt = '0;
                        if (!w_pass_end) begin
                            w_sel_nxt = pat_next(r_sel, c_last_code);
                        end
                    end else begin
                        w_dwell_cnt_nxt = w_dwell_inc;
                    end
                end
                // The frame that coincides with stop still counts before stopping.
                if (w_pass_end) begin
                    w_state_nxt  = ST_IDLE;
                    w_gen_en_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end else if (stop) begin
                    w_state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (w_frame_end) begin
                    w_state_nxt  = ST_IDLE;
                    w_gen_en_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_gen_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_gen_en    <= 1'b0;
            r_sel       <= 3'd0;
            r_fcnt      <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
            r_cfg_first <= 3'd0;
            r_cfg_dwell <= FCNT_W'(1);
            r_cfg_loop  <= 1'b0;
            r_su_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gen_en    <= w_gen_en_nxt;
            r_sel       <= w_sel_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_done      <= w_done_nxt;
            r_cfg_first <= w_cfg_first_nxt;
            r_cfg_dwell <= w_cfg_dwell_nxt;
            r_cfg_loop  <= w_cfg_loop_nxt;
            if (!w_startup_done) begin
                r_su_cnt <= r_su_cnt + c_su_w'(1);
            end
        end
    end

    assign gen_en      = r_gen_en;
    assign pattern_sel = r_sel;
    assign frame_cnt   = r_fcnt;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_raw_pattern_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_raw_pattern_sequencer                                               |
// | Random frame/command stimulus checked cycle by cycle against a model.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_raw_pattern_sequencer;

    localparam int NUM  = 6;
    localparam int FW   = 11;
    localparam int SU   = 128;
    localparam int FMAX = (1 << FW) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_STOP  = 3;

    typedef struct packed {
        logic          ready;
        logic          gen;
        logic [2:0]    sel;
        logic [FW-1:0] fcnt;
        logic          busy;
        logic          done;
    } obs_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fv;
    logic          start;
    logic          stop;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_first;
    logic [FW-1:0] cfg_dwell;
    logic          cfg_loop;
    logic          gen_en;
    logic [2:0]    pattern_sel;
    logic [FW-1:0] frame_cnt;
    logic          busy;
    logic          done;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t exp_q[$];
    bit   fast_fv    = 1'b0;
    bit   arm_async  = 1'b0;

    // Reference model state
    int m_phase, m_sel, m_fcnt, m_k, m_su, m_first, m_dwell;
    bit m_gen, m_done, m_loop, m_fv_prev;

    raw_pattern_sequencer #(
        .NUM_PATTERNS (NUM),
        .FCNT_W       (FW),
        .STARTUP_CLKS (SU)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fv          (fv),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_first   (cfg_first),
        .cfg_dwell   (cfg_dwell),
        .cfg_loop    (cfg_loop),
        .gen_en      (gen_en),
        .pattern_sel (pattern_sel),
        .frame_cnt   (frame_cnt),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: pattern after k run frames is (first + k/dwell) mod NUM.
    task automatic model_step();
        obs_t e;
        bit   fe, rdy_pre;
        if (!rstn) begin
            m_phase = PH_IDLE; m_gen = 0; m_sel = 0; m_fcnt = 0; m_done = 0; m_k = 0;
            m_su = 0; m_fv_prev = 0; m_first = 0; m_dwell = 1; m_loop = 0;
        end else begin
            fe        = m_fv_prev && !fv;
            m_fv_prev = fv;
            rdy_pre   = (m_phase == PH_IDLE) && (m_su >= SU);
            if (m_su < SU) m_su++;
            m_done = 0;
            case (m_phase)
                PH_IDLE: begin
                    if (start && !stop && rdy_pre) begin
                        m_phase = PH_ARMED; m_sel = m_first; m_fcnt = 0; m_k = 0;
                    end
                end
                PH_ARMED: begin
                    if (stop) begin
                        m_phase = PH_IDLE; m_done = 1;
                    end else if (fe) begin
                        m_phase = PH_RUN; m_gen = 1;
                    end
                end
                PH_RUN: begin
                    if (fe) begin
                        m_k++;
                        m_fcnt = (m_k > FMAX) ? FMAX : m_k;
                        if (!m_loop && m_k == NUM * m_dwell) begin
                            m_phase = PH_IDLE; m_gen = 0; m_done = 1;
                        end else begin
                            m_sel = (m_first + m_k / m_dwell) % NUM;
                        end
                    end
                    if (stop && m_phase == PH_RUN) m_phase = PH_STOP;
                end
                default: begin
                    if (fe) begin
                        m_phase = PH_IDLE; m_gen = 0; m_done = 1;
                    end
                end
            endcase
            if (cfg_valid && rdy_pre) begin
                m_first = (int'(cfg_first) >= NUM) ? 0 : int'(cfg_first);
                m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
                m_loop  = cfg_loop;
            end
        end
        e.ready = (m_phase == PH_IDLE) && (m_su >= SU);
        e.gen   = m_gen;
        e.sel   = 3'(m_sel);
        e.fcnt  = FW'(m_fcnt);
        e.busy  = (m_phase != PH_IDLE);
        e.done  = m_done;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare presented status against the oldest expectation.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {cfg_ready, gen_en, pattern_sel, frame_cnt, busy, done};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL status t=%0t: got rdy=%0b gen=%0b sel=%0d fcnt=%0d busy=%0b done=%0b, required rdy=%0b gen=%0b sel=%0d fcnt=%0d busy=%0b done=%0b",
                             $time, a.ready, a.gen, a.sel, a.fcnt, a.busy, a.done,
                             e.ready, e.gen, e.sel, e.fcnt, e.busy, e.done);
                end
            end
        end
    end

    // Reset must clear outputs without waiting for a clock edge.
    initial begin
        forever begin
            @(negedge rstn);
            #1;
            if (arm_async) begin
                n_vec++;
                if ({gen_en, busy, done, cfg_ready, pattern_sel, frame_cnt} !== '0) begin
                    n_err++;
                    $display("FAIL async_reset: got gen=%0b busy=%0b done=%0b rdy=%0b sel=%0d fcnt=%0d, required all 0",
                             gen_en, busy, done, cfg_ready, pattern_sel, frame_cnt);
                end
            end
        end
    end

    // Free-running frame source, independent of the command stream.
    initial begin
        int h, l;
        fv = 1'b0;
        @(posedge clk);
        #1;
        forever begin
            h = fast_fv ? 2 : int'($urandom_range(3, 12));
            l = fast_fv ? 1 : int'($urandom_range(2, 5));
            fv = 1'b1;
            step(h);
            fv = 1'b0;
            step(l);
        end
    end

    task automatic pulse_start(input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic offer_cfg(input logic [2:0] f, input logic [FW-1:0] d, input logic lp);
        cfg_valid = 1'b1;
        cfg_first = f;
        cfg_dwell = d;
        cfg_loop  = lp;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
            pulse_stop();
            step(60);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_first = '0; cfg_dwell = '0; cfg_loop = 1'b0;
        step(3);
        rstn = 1'b1;
        arm_async = 1'b1;

        // Early start ignored; configuration and start after startup.
        step(49);
        pulse_start(1'b0);
        step(80);
        offer_cfg(3'd4, FW'(2), 1'b1);
        step(68);
        pulse_start(1'b0);
        step(120);
        pulse_stop();
        wait_idle(200);

        // Single pass, dwell 1, from pattern 0.
        offer_cfg(3'd0, FW'(1), 1'b0);
        step(3);
        pulse_start(1'b0);
        wait_idle(400);
        step(5);

        // Start and stop together, then out-of-range first and zero dwell.
        pulse_start(1'b1);
        step(10);
        offer_cfg(3'd7, FW'(0), 1'b1);
        pulse_start(1'b0);
        step(70);
        pulse_stop();
        wait_idle(200);

        // Reset in the middle of a run, between clock edges.
        offer_cfg(3'd2, FW'(2), 1'b1);
        pulse_start(1'b0);
        step(80);
        #6;
        rstn = 1'b0;
        step(3);
        rstn = 1'b1;
        step(SU + 2);

        // Random episodes.
        for (int ep = 0; ep < 40; ep++) begin
            offer_cfg(3'($urandom_range(0, 7)), FW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 20));
            pulse_start($urandom_range(0, 7) == 0);
            step($urandom_range(0, 60));
            if ($urandom_range(0, 3) == 0) pulse_start(1'b0);
            if (cfg_loop || $urandom_range(0, 1) == 1) begin
                step($urandom_range(0, 15));
                pulse_stop();
            end
            wait_idle(1000);
            step($urandom_range(1, 6));
        end

        // Long fast-frame run drives frame_cnt into saturation.
        fast_fv = 1'b1;
        offer_cfg(3'd5, FW'(5), 1'b1);
        pulse_start(1'b0);
        step(6400);
        pulse_stop();
        wait_idle(100);
        fast_fv = 1'b0;
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raw_pattern_sequencer.md
RAW_PATTERN_SEQUENCER -- requirements
Module: raw_pattern_sequencer

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 6: number of pattern codes, 1..8.
REQ-002 SHALL have parameter FCNT_W, default 11: width of the frame and dwell counters.
REQ-003 SHALL have parameter STARTUP_CLKS, default 128: clocks after reset release before any command is accepted.
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 SHALL have port `rstn`, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port `fv`, input, 1 bit: frame valid from the raw pattern generator.
REQ-007 SHALL have port `start`, input, 1 bit: single-cycle pulse that begins a sequence.
REQ-008 SHALL have port `stop`, input, 1 bit: single-cycle pulse that ends the sequence at the next frame end.
REQ-009 SHALL have port `cfg_valid`, input, 1 bit: configuration offered.
REQ-010 SHALL have port `cfg_ready`, output, 1 bit: configuration can be accepted.
REQ-011 SHALL have port `cfg_first`, input, 3 bits: first pattern code.
REQ-012 SHALL have port `cfg_dwell`, input, FCNT_W bits: frames per pattern.
REQ-013 SHALL have port `cfg_loop`, input, 1 bit: wrap forever when 1, run a single pass when 0.
REQ-014 SHALL have port `gen_en`, output, 1 bit: enables the generator datapath.
REQ-015 SHALL have port `pattern_sel`, output, 3 bits: active pattern code.
REQ-016 SHALL have port `frame_cnt`, output, FCNT_W bits: frames completed since start, saturating.
REQ-017 SHALL have port `busy`, output, 1 bit: high whenever the state is not IDLE.
REQ-018 SHALL have port `done`, output, 1 bit: single-cycle pulse on return to IDLE.

Function
REQ-019 SHALL register `fv` into fv_q; frame_end = fv_q & ~fv, i.e. the first rising edge after `fv` falls.
REQ-020 SHALL count STARTUP_CLKS from reset release in a startup counter; until it completes, `cfg_ready` = 0 and `start` is ignored.
REQ-021 SHALL implement states IDLE, ARMED, RUN and STOPPING.
REQ-022 SHALL drive `cfg_ready` = 1 only in IDLE after startup; on `cfg_valid` & `cfg_ready`, latch first, dwell and loop.
REQ-023 SHALL latch a `cfg_dwell` of 0 as 1.
REQ-024 SHALL latch a `cfg_first` >= NUM_PATTERNS as 0.
REQ-025 SHALL, on IDLE with `start` (and no `stop`), go to ARMED; `pattern_sel` <= latched first; `frame_cnt` <= 0.
REQ-026 SHALL, in ARMED, on frame_end go to RUN and set `gen_en` = 1 in the same update, so enabling always happens in vertical blanking.
REQ-027 SHALL, in RUN, on each frame_end increment `frame_cnt` (saturating at all-ones) and the dwell counter.
REQ-028 SHALL, when the dwell counter reaches dwell, clear it and advance `pattern_sel`, wrapping from NUM_PATTERNS-1 to 0.
REQ-029 SHALL, with loop = 0, go to IDLE on the frame_end that completes the dwell of pattern (first+NUM_PATTERNS-1) mod NUM_PATTERNS, with `gen_en` <= 0 and `done` = 1 for one cycle.
REQ-030 SHALL, on `stop` in ARMED, go straight to IDLE with `done` pulsed and `gen_en` left 0.
REQ-031 SHALL, on `stop` in RUN, go to STOPPING.
REQ-032 SHALL, in STOPPING, on the next frame_end set `gen_en` <= 0, go to IDLE and pulse `done`.
REQ-033 SHALL give `stop` priority when `start` and `stop` arrive in the same cycle; `start` outside IDLE is ignored.
REQ-034 SHALL process a frame_end in the same cycle as `stop` in RUN as a normal RUN frame (count and advance), then enter STOPPING.
REQ-035 SHALL hold `pattern_sel` constant except on a frame_end edge.
REQ-036 SHALL keep `pattern_sel` and `frame_cnt` at their last values in IDLE until the next start.

Reset
REQ-037 SHALL, while `rstn` = 0, asynchronously force: state IDLE; `gen_en`, `busy`, `done`, `cfg_ready` = 0; `pattern_sel`, `frame_cnt`, dwell counter, fv_q and startup counter = 0; latched config to first 0, dwell 1, loop 0.
REQ-038 SHALL abort any operation immediately on reset mid-operation, with no `done` pulse.

Structure
REQ-039 SHALL define pattern codes in shared package raw_gen_pkg: 0 COLORBAR, 1 RED, 2 GREEN, 3 BLUE, 4 CHECKER, 5 WHITE.
REQ-040 SHALL define the state enum and the startup constant in raw_gen_pkg.
REQ-041 SHALL place fv registration and frame_end generation in sub-module frame_edge_det.

Verification
REQ-042 SHALL check reset release, then `start` at clk 50 and clk 200 -> first ignored; `cfg_ready` rises at clk 128.
REQ-043 SHALL check cfg first=4, dwell=2, loop=1, NUM_PATTERNS=6, `start` -> `pattern_sel` 4,4,5,5,0,0,1 on successive frame_ends; `gen_en` rises only on the first frame_end.
REQ-044 SHALL check loop=0, dwell=1, first=0 -> `done` on the 6th RUN frame_end; `frame_cnt` = 6; `gen_en` = 0.
REQ-045 SHALL check `stop` mid-frame in RUN -> `gen_en` stays 1 until the next `fv` fall, then 0; `done` pulses once.
REQ-046 SHALL check `start` and `stop` in the same cycle in IDLE -> state stays IDLE, no `done`; cfg_dwell=0 then runs with dwell 1.
REQ-047 SHALL check `rstn` low mid-RUN -> all outputs 0 asynchronously, no `done`.
